// File: rtl/qos_stream_arbiter_pkg.sv
// qos_stream_arbiter_pkg: shared state encoding and QoS weight helper
package qos_stream_arbiter_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

    function automatic int unsigned qos_weight(input int unsigned q);
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/qos_stream_arbiter_rr_pick.sv
// qos_stream_arbiter_rr_pick: lowest-index priority arbiter and round-robin picker built from two of them
module simple_priority_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    assign gnt_o = req_i & (~req_i + N'(1));

endmodule

module rr_pick
    import qos_stream_arbiter_pkg::*;
#(
    parameter int STREAM_COUNT = 2,
    parameter int IW           = $clog2(STREAM_COUNT)
) (
    input  logic [STREAM_COUNT-1:0] req_i,
    input  logic [IW-1:0]           ptr_i,
    output logic [STREAM_COUNT-1:0] gnt_o,
    output logic [IW-1:0]           idx_o
);

    logic [STREAM_COUNT-1:0] mask;
    logic [STREAM_COUNT-1:0] masked;
    logic [STREAM_COUNT-1:0] gnt_m;
    logic [STREAM_COUNT-1:0] gnt_u;

    // only requests strictly above the last winner compete in the masked pass
    always_comb begin
        for (int i = 0; i < STREAM_COUNT; i++) mask[i] = i > int'(ptr_i);
    end

    assign masked = req_i & mask;

    simple_priority_arbiter #(.N(STREAM_COUNT)) u_masked (.req_i(masked), .gnt_o(gnt_m));
    simple_priority_arbiter #(.N(STREAM_COUNT)) u_plain  (.req_i(req_i),  .gnt_o(gnt_u));

    // masked winner first, otherwise wrap to the lowest requester
    always_comb begin
        gnt_o = |masked ? gnt_m : gnt_u;
        idx_o = '0;
        for (int i = 0; i < STREAM_COUNT; i++) if (gnt_o[i]) idx_o = idx_o | IW'(i);
    end

endmodule

// File: rtl/qos_stream_arbiter.sv
// qos_stream_arbiter: packet-atomic QoS-weighted round-robin stream merger
module qos_stream_arbiter
    import qos_stream_arbiter_pkg::*;
#(
    parameter int STREAM_COUNT = 2,
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH  = 4,
    parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]  s_qos_i,
    input  logic [STREAM_COUNT-1:0]                   s_last_i,
    input  logic [STREAM_COUNT-1:0]                   s_valid_i,
    output logic [STREAM_COUNT-1:0]                   s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                   m_data_o,
    output logic [T_QOS_WIDTH-1:0]                    m_qos_o,
    output logic [T_ID_WIDTH-1:0]                     m_id_o,
    output logic                                      m_last_o,
    output logic                                      m_valid_o,
    input  logic                                      m_ready_i
);

    arb_state_t                                   state_q, state_d;
    logic [T_ID_WIDTH-1:0]                        sel_q, sel_d;
    logic [T_ID_WIDTH-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]     credit_q, credit_d;
    logic [STREAM_COUNT-1:0]                      eligible;
    logic [STREAM_COUNT-1:0]                      pick_gnt;
    logic [T_ID_WIDTH-1:0]                        pick_idx;
    logic                                         busy;

    // a stream may win only while it is valid and still holds credit this round
    always_comb begin
        for (int i = 0; i < STREAM_COUNT; i++) eligible[i] = s_valid_i[i] & (credit_q[i] != '0);
    end

    rr_pick #(.STREAM_COUNT(STREAM_COUNT), .IW(T_ID_WIDTH)) u_pick (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // state register; reset gives stream 0 first priority and empties all credit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= T_ID_WIDTH'(STREAM_COUNT - 1);
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
        end
    end

    // next state: grant or reload while idle, release the grant on the transferred last beat
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        credit_d = credit_q;
        if (state_q == IDLE) begin
            if (|eligible) begin
                state_d  = BUSY;
                sel_d    = pick_idx;
                rr_ptr_d = pick_idx;
                for (int i = 0; i < STREAM_COUNT; i++)
                    if (pick_gnt[i]) credit_d[i] = credit_q[i] - T_QOS_WIDTH'(1);
            end else if (|s_valid_i) begin
                for (int i = 0; i < STREAM_COUNT; i++)
                    credit_d[i] = T_QOS_WIDTH'(qos_weight(32'(s_qos_i[i])));
            end
        end else if (m_valid_o && m_ready_i && m_last_o) begin
            state_d = IDLE;
        end
    end

    assign busy = state_q == BUSY;

    // outputs: forward the selected stream while busy, drive zeros otherwise
    always_comb begin
        m_valid_o = busy & s_valid_i[sel_q];
        m_data_o  = busy ? s_data_i[sel_q] : '0;
        m_qos_o   = busy ? s_qos_i[sel_q] : '0;
        m_last_o  = busy & s_last_i[sel_q];
        m_id_o    = busy ? sel_q : '0;
        s_ready_o = '0;
        if (busy) s_ready_o[sel_q] = m_ready_i;
    end

endmodule

// File: tb/tb_qos_stream_arbiter.sv
// tb_qos_stream_arbiter: directed table, corner sequences and random traffic against a behavioural model
module tb_qos_stream_arbiter;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0][7:0]   s_data = '0;
    logic [N-1:0][3:0]   s_qos = '0;
    logic [N-1:0]        s_last = '0;
    logic [N-1:0]        s_valid = '0;
    logic [N-1:0]        s_ready;
    logic [7:0]          m_data;
    logic [3:0]          m_qos;
    logic [1:0]          m_id;
    logic                m_last;
    logic                m_valid;
    logic                m_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    bit md_busy;
    int md_sel;
    int md_ptr;
    int md_cred[N];

    logic       smp_valid;
    logic [1:0] smp_id;
    logic [7:0] smp_data;
    logic [N-1:0] smp_ready;

    typedef struct {
        logic [3:0] v;
        logic [7:0] d0;
        logic       l0;
        logic       mr;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [3:0] er;
    } vec_t;

    qos_stream_arbiter #(
        .STREAM_COUNT (N),
        .T_DATA_WIDTH (8),
        .T_QOS_WIDTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_qos_i   (s_qos),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_qos_o   (m_qos),
        .m_id_o    (m_id),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_busy = 1'b0;
        md_sel  = 0;
        md_ptr  = N - 1;
        foreach (md_cred[i]) md_cred[i] = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_s_ready", 32'(s_ready), 32'(0));
        chk("rst_m_data",  32'(m_data),  32'(0));
        chk("rst_m_id",    32'(m_id),    32'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // compare outputs against the model for the current inputs, then advance one clock
    task automatic step();
        logic       ev, el;
        logic [7:0] ed;
        logic [3:0] eq, er;
        logic [1:0] eid;
        bit nb;
        int ns, np, pick;
        int nc[N];
        #1;
        ev  = md_busy && s_valid[md_sel];
        ed  = md_busy ? s_data[md_sel] : 8'h00;
        eq  = md_busy ? s_qos[md_sel] : 4'h0;
        el  = md_busy && s_last[md_sel];
        eid = md_busy ? 2'(md_sel) : 2'd0;
        er  = 4'b0000;
        if (md_busy) er[md_sel] = m_ready;
        chk("m_valid", 32'(m_valid), 32'(ev));
        chk("m_data",  32'(m_data),  32'(ed));
        chk("m_qos",   32'(m_qos),   32'(eq));
        chk("m_last",  32'(m_last),  32'(el));
        chk("m_id",    32'(m_id),    32'(eid));
        chk("s_ready", 32'(s_ready), 32'(er));
        smp_valid = m_valid;
        smp_id    = m_id;
        smp_data  = m_data;
        smp_ready = s_ready;
        nb = md_busy;
        ns = md_sel;
        np = md_ptr;
        nc = md_cred;
        if (!md_busy) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (md_ptr + k) % N;
                if (pick < 0 && s_valid[c] && md_cred[c] > 0) pick = c;
            end
            if (pick >= 0) begin
                nb = 1'b1;
                ns = pick;
                np = pick;
                nc[pick] = nc[pick] - 1;
            end else if (|s_valid) begin
                for (int i = 0; i < N; i++) nc[i] = (s_qos[i] == 0) ? 1 : int'(s_qos[i]);
            end
        end else if (s_valid[md_sel] && m_ready && s_last[md_sel]) begin
            nb = 1'b0;
        end
        @(posedge clk);
        md_busy = nb;
        md_sel  = ns;
        md_ptr  = np;
        md_cred = nc;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[8];
        int   ord[5];
        int   cnt[N];
        int   pk, beat;
        int   exp_ord[4] = '{0, 1, 0, 0};

        do_reset();

        // single-stream packets with hand-derived outputs: reload, grant, two beats, idle, stalled single beat
        tbl[0] = '{4'b0001, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000};
        tbl[1] = '{4'b0001, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000};
        tbl[2] = '{4'b0001, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 4'b0001};
        tbl[3] = '{4'b0001, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b1, 4'b0001};
        tbl[4] = '{4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000};
        tbl[5] = '{4'b0001, 8'hB1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000};
        tbl[6] = '{4'b0001, 8'hB1, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b1, 4'b0000};
        tbl[7] = '{4'b0001, 8'hB1, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b1, 4'b0001};
        s_qos = '0;
        s_qos[0] = 4'd3;
        for (int i = 0; i < 8; i++) begin
            s_valid   = tbl[i].v;
            s_data[0] = tbl[i].d0;
            s_last[0] = tbl[i].l0;
            m_ready   = tbl[i].mr;
            #1;
            chk("tbl_valid", 32'(m_valid), 32'(tbl[i].ev));
            chk("tbl_data",  32'(m_data),  32'(tbl[i].ed));
            chk("tbl_last",  32'(m_last),  32'(tbl[i].el));
            chk("tbl_ready", 32'(s_ready), 32'(tbl[i].er));
            chk("tbl_id",    32'(m_id),    32'(0));
            step();
            if (i == 4) chk("tbl_credit0", 32'(dut.credit_q[0]), 32'(2));
        end

        // weighted sharing: qos0=3, qos1=1, single-beat packets
        do_reset();
        s_valid = 4'b0011;
        s_last  = '1;
        s_qos   = '0;
        s_qos[0] = 4'd3;
        s_qos[1] = 4'd1;
        m_ready = 1'b1;
        pk = 0;
        foreach (cnt[i]) cnt[i] = 0;
        for (int cyc = 0; cyc < 400 && pk < 40; cyc++) begin
            s_data = $urandom;
            step();
            if (smp_valid) begin
                if (pk < 4) ord[pk] = int'(smp_id);
                cnt[smp_id]++;
                pk++;
            end
        end
        chk("wrr_packets", 32'(pk), 32'(40));
        for (int i = 0; i < 4; i++) chk("wrr_order", 32'(ord[i]), 32'(exp_ord[i]));
        chk("wrr_cnt0", 32'(cnt[0]), 32'(30));
        chk("wrr_cnt1", 32'(cnt[1]), 32'(10));

        // four-beat packet on stream 0 while stream 1 waits
        do_reset();
        s_valid = 4'b0011;
        s_qos   = '0;
        s_last  = 4'b0010;
        m_ready = 1'b1;
        beat = 0;
        for (int cyc = 0; cyc < 20 && beat < 4; cyc++) begin
            s_last[0] = (beat == 3);
            s_data[0] = 8'h10 + 8'(beat);
            s_data[1] = 8'hEE;
            step();
            if (smp_valid) begin
                chk("atomic_id",    32'(smp_id),       32'(0));
                chk("atomic_rdy1",  32'(smp_ready[1]), 32'(0));
                chk("atomic_data",  32'(smp_data),     32'(8'h10 + 8'(beat)));
                beat++;
            end
        end
        chk("atomic_beats", 32'(beat), 32'(4));
        s_valid = '0;
        step();

        // downstream stalls every other cycle mid-packet
        do_reset();
        s_valid = 4'b0001;
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
            m_ready   = (cyc % 2 == 0);
            s_data[0] = 8'h40 + 8'(beat);
            s_last[0] = (beat == 3);
            step();
            if (smp_valid) begin
                chk("stall_data",  32'(smp_data),     32'(8'h40 + 8'(beat)));
                chk("stall_ready", 32'(smp_ready[0]), 32'(m_ready));
                if (m_ready) beat++;
            end
        end
        chk("stall_beats", 32'(beat), 32'(4));

        // qos 0 everywhere: strict rotation
        do_reset();
        s_valid = '1;
        s_qos   = '0;
        s_last  = '1;
        m_ready = 1'b1;
        pk = 0;
        for (int cyc = 0; cyc < 100 && pk < 5; cyc++) begin
            s_data = $urandom;
            step();
            if (smp_valid) begin
                ord[pk] = int'(smp_id);
                pk++;
            end
        end
        chk("rot_packets", 32'(pk), 32'(5));
        for (int i = 0; i < 5; i++) chk("rot_order", 32'(ord[i]), 32'(i % N));

        // reset in the middle of a packet at an arbitrary phase
        do_reset();
        s_valid = 4'b0011;
        s_last  = '0;
        s_qos   = '0;
        m_ready = 1'b1;
        repeat (4) step();
        #($urandom_range(1, 8));
        do_reset();
        s_valid = '1;
        s_last  = '1;
        pk = 0;
        for (int cyc = 0; cyc < 20 && pk == 0; cyc++) begin
            step();
            if (smp_valid) begin
                chk("rst_first_id", 32'(smp_id), 32'(0));
                pk++;
            end
        end
        chk("rst_first_seen", 32'(pk), 32'(1));

        // random traffic checked cycle by cycle against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_valid = 4'($urandom);
            s_data  = $urandom;
            s_qos   = 16'($urandom);
            s_last  = 4'($urandom) & 4'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qos_stream_arbiter.md
Name: qos_stream_arbiter

Overview:
- Packet-atomic N-input stream arbiter with QoS-weighted round-robin; successor of the combinational fixed-priority arbiter.
- Merges STREAM_COUNT valid/ready streams onto one output stream.
- A granted packet is never interleaved: the grant is held until the beat carrying last completes.
- Each stream receives packet slots in proportion to its QoS weight per arbitration round.

Parameters:
- STREAM_COUNT, 2, number of input streams (>=2)
- T_DATA_WIDTH, 8, data bits per beat
- T_QOS_WIDTH, 4, QoS field width
- T_ID_WIDTH, $clog2(STREAM_COUNT), width of granted-stream index

Ports:
- clk  input  1  single clock
- rst_n  input  1  reset, asynchronous, active-low
- s_data_i  input  [STREAM_COUNT][T_DATA_WIDTH]  per-stream data
- s_qos_i  input  [STREAM_COUNT][T_QOS_WIDTH]  per-stream QoS; 0 means weight 1
- s_last_i  input  [STREAM_COUNT]  last beat of packet
- s_valid_i  input  [STREAM_COUNT]  beat valid
- s_ready_o  output  [STREAM_COUNT]  beat accepted
- m_data_o  output  T_DATA_WIDTH  granted data
- m_qos_o  output  T_QOS_WIDTH  granted stream's qos
- m_id_o  output  T_ID_WIDTH  granted stream index
- m_last_o  output  1  last beat
- m_valid_o  output  1  output valid
- m_ready_i  input  1  downstream ready

Behaviour:
- State IDLE / BUSY. Registers: state, sel (T_ID_WIDTH), rr_ptr (T_ID_WIDTH), credit[i] (T_QOS_WIDTH bits each).
- Reset (async, rst_n=0) takes effect immediately:
  - state=IDLE, sel=0, rr_ptr=STREAM_COUNT-1 so stream 0 has first priority, all credit=0.
  - All outputs go 0.
- weight(q) = (q==0) ? 1 : q.
- IDLE, one decision per cycle; m_valid_o=0 and s_ready_o=0 throughout:
  - eligible = s_valid_i & (credit!=0).
  - If eligible!=0: round-robin pick of the first eligible index after rr_ptr, wrapping modulo STREAM_COUNT. Then sel<=pick, rr_ptr<=pick, credit[pick]<=credit[pick]-1, state<=BUSY.
  - Else if s_valid_i!=0 (reload cycle): credit[i]<=weight(s_qos_i[i]) for every i, including non-valid streams. Stay in IDLE; no grant in the same cycle.
  - Else: hold.
- BUSY, combinational forwarding from stream sel:
  - m_valid_o=s_valid_i[sel].
  - m_data_o, m_qos_o and m_last_o are taken from stream sel; m_id_o=sel.
  - s_ready_o[sel]=m_ready_i; all other s_ready_o bits are 0.
  - A beat transfers when m_valid_o & m_ready_i.
  - Transfer with m_last_o=1: state<=IDLE.
  - Gaps with s_valid_i[sel]=0 keep BUSY and keep the grant.
- Latency: first beat of a packet appears no earlier than 1 cycle after the grant decision (2 cycles if a reload is needed). There is one IDLE bubble between consecutive packets.
- Outside BUSY: m_valid_o=0, m_data_o, m_qos_o, m_id_o and m_last_o=0 (no X propagation).
- Credits only change in IDLE; QoS changes during BUSY have no effect until the next reload.
- A stream that drops valid while idle keeps its remaining credit until the next reload.
- A single-beat packet (valid & last on the first beat) is legal: BUSY lasts 1 cycle if m_ready_i=1.
- Reset mid-packet: the packet is abandoned; no recovery beyond the reset values.
- Downstream must not depend on s_valid_i being held; the arbiter adds no buffering.

Decomposition:
- Package qos_stream_arbiter_pkg holds:
  - enum arb_state_t {IDLE, BUSY}.
  - function qos_weight(q) implementing weight().
- Sub-module rr_pick(STREAM_COUNT):
  - Masked-request round-robin built from two simple_priority_arbiter instances (masked above rr_ptr, then unmasked).
  - Outputs a one-hot pick plus an encoded index.

Test Plan:
- Reset, then s_valid_i=2'b01, qos0=3, 2-beat packet, m_ready_i=1:
  - Reload cycle, then grant cycle.
  - Beats appear at the output with m_id_o=0 and last on beat 2.
  - credit[0]=2 afterwards.
- Both streams continuously valid, single-beat packets, qos0=3, qos1=1, m_ready_i=1:
  - Per round the grant order is 0,1,0,0, then reload.
  - Throughput ratio 3:1 over 40 packets.
- Stream 0 sends a 4-beat packet while stream 1 is valid throughout:
  - No stream-1 beat is interleaved.
  - s_ready_o[1]=0 until stream 0's last beat transfers.
- m_ready_i toggles 1,0,1,0 mid-packet:
  - m_data_o is stable while stalled.
  - s_ready_o[sel] mirrors m_ready_i.
  - No beat is duplicated or lost.
- qos=0 on both streams, STREAM_COUNT=4, all valid: strict rotation 0,1,2,3,0, with one reload per round.
- rst_n deasserted-to-0 mid-packet at an arbitrary clock phase:
  - Outputs go 0 immediately.
  - After release, stream 0 is granted first.
